// File: rtl/permutation_round_controller.sv
// Round sequencer for the ASCON permutation datapath: load strobe,
// per-round enable, round-constant index and result handshake.
module permutation_round_controller #(
  parameter int G_ROUND_WIDTH = 4,
  parameter int G_MAX_ROUNDS  = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [G_ROUND_WIDTH-1:0] rounds,
  input  logic                     abort,
  output logic                     load_state,
  output logic                     round_enable,
  output logic [G_ROUND_WIDTH-1:0] round_idx,
  output logic                     busy,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [G_ROUND_WIDTH-1:0] MAX_R =
    G_ROUND_WIDTH'(G_MAX_ROUNDS);
  localparam logic [G_ROUND_WIDTH-1:0] LAST_R =
    G_ROUND_WIDTH'(G_MAX_ROUNDS - 1);

  state_t                   state_q;
  state_t                   state_d;
  logic [G_ROUND_WIDTH-1:0] idx_q;
  logic [G_ROUND_WIDTH-1:0] idx_d;
  logic                     err_q;
  logic                     err_d;
  logic                     req_ok;

  assign req_ok = (rounds != '0) && (rounds <= MAX_R);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Abort outranks every other transition outside IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            if (req_ok) begin
              state_d = S_LOAD;
              idx_d   = MAX_R - rounds;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: state_d = S_ROUND;
        S_ROUND: begin
          if (idx_q == LAST_R) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign load_state   = (state_q == S_LOAD);
  assign round_enable = (state_q == S_ROUND);
  assign result_valid = (state_q == S_DONE);
  assign round_idx    = idx_q;
  assign error        = err_q;

endmodule
